md5_msg_padder: RTL and testbench

Front end of the MD5 datapath. It converts a raw byte stream into padded 512-bit message blocks and emits them as a stream of 32-bit little-endian words: the m input consumed by the round logic. It implements RFC 1321 padding: a 0x80 byte, zero fill to 56 mod 64, then the 64-bit message bit length, low word first. It also generates word-index and block-boundary markers for the round controller.

---
 rtl/md5_pkg.sv | 17 +
 rtl/md5_byte_packer.sv | 67 ++++++
 rtl/md5_msg_padder.sv | 193 +++++++++++++++++++
 tb/tb_md5_msg_padder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/md5_pkg.sv
// Shared types and constants for the MD5 message padding front end.
package md5_pkg;

   typedef enum logic [1:0] {
      S_DATA,
      S_PAD_ZERO,
      S_LEN_LO,
      S_LEN_HI
   } state_e;

   localparam logic [7:0]  PAD_BYTE        = 8'h80;
   localparam int unsigned WORDS_PER_BLOCK = 16;
   localparam logic [3:0]  LEN_IDX_LO      = 4'd14;
   localparam logic [3:0]  LEN_IDX_HI      = 4'd15;
   localparam logic [3:0]  LAST_PAD_IDX    = 4'd13;

endpackage

// File: rtl/md5_byte_packer.sv
// Byte lane counter and little-endian word assembler with 0x80 / zero-fill insertion.
module md5_byte_packer
   import md5_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr_i,
   input  logic        push_i,
   input  logic        keep_i,
   input  logic        last_i,
   input  logic [7:0]  data_i,
   output logic [31:0] word_o,
   output logic        word_valid_o,
   output logic        pad_pend_o
);

   logic [1:0]       k_q, k_d;
   logic [3:0][7:0]  lanes_q, lanes_d;

   // Word as it would look if loaded by the current beat: stored lanes, this byte or 0x80, zeros
   always_comb begin
      word_o = '0;
      for (int j = 0; j < 4; j++) begin
         if (2'(j) < k_q) begin
            word_o[8*j +: 8] = lanes_q[j];
         end else if (2'(j) == k_q) begin
            word_o[8*j +: 8] = keep_i ? data_i : PAD_BYTE;
         end else if ((3'(j) == ({1'b0, k_q} + 3'd1)) && keep_i && last_i) begin
            word_o[8*j +: 8] = PAD_BYTE;
         end
      end
   end

   assign word_valid_o = push_i && (last_i || (keep_i && (k_q == 2'd3)));
   // A final byte that fills lane 3 leaves no room for 0x80; it follows in its own word
   assign pad_pend_o   = push_i && last_i && keep_i && (k_q == 2'd3);

   // Next lane position and stored bytes
   always_comb begin
      k_d     = k_q;
      lanes_d = lanes_q;
      if (clr_i) begin
         k_d = 2'd0;
      end else if (push_i) begin
         if (keep_i) begin
            lanes_d[k_q] = data_i;
         end
         if (last_i) begin
            k_d = 2'd0;
         end else if (keep_i) begin
            k_d = k_q + 2'd1;
         end
      end
   end

   // Lane state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_q     <= 2'd0;
         lanes_q <= '0;
      end else begin
         k_q     <= k_d;
         lanes_q <= lanes_d;
      end
   end

endmodule

// File: rtl/md5_msg_padder.sv
// MD5 front end: byte stream in, RFC 1321 padded 512-bit blocks out as 32-bit LE words.
module md5_msg_padder
   import md5_pkg::*;
#(
   parameter int unsigned LEN_W = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        abort,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   input  logic        in_keep,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_word,
   output logic [3:0]  out_idx,
   output logic        out_block_first,
   output logic        out_block_last,
   output logic        out_msg_last
);

   state_e            state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [3:0]        widx_q, widx_d;     // index the next emitted word will carry
   logic              pad80_q, pad80_d;   // 0x80 word still owed after a full final data word
   logic              rdy_en_q;           // holds in_ready low for the first cycle out of reset
   logic              out_valid_q, out_valid_d;
   logic [31:0]       out_word_q, out_word_d;
   logic [3:0]        out_idx_q, out_idx_d;
   logic              first_q, first_d, blast_q, blast_d, mlast_q, mlast_d;

   logic              free, accept;
   logic [63:0]       len_ext;
   logic [31:0]       pk_word;
   logic              pk_word_valid, pk_pad_pend;
   logic              load, ld_mlast;
   logic [31:0]       ld_word;

   assign free     = !out_valid_q || out_ready;
   assign in_ready = rdy_en_q && (state_q == S_DATA) && free;
   assign accept   = in_valid && in_ready;
   assign len_ext  = 64'(len_q);

   md5_byte_packer u_packer (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr_i        (abort),
      .push_i       (accept && !abort),
      .keep_i       (in_keep),
      .last_i       (in_last),
      .data_i       (in_data),
      .word_o       (pk_word),
      .word_valid_o (pk_word_valid),
      .pad_pend_o   (pk_pad_pend)
   );

   // Next state: FSM, length counter, word index and output register load
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      widx_d      = widx_q;
      pad80_d     = pad80_q;
      out_valid_d = out_valid_q;
      out_word_d  = out_word_q;
      out_idx_d   = out_idx_q;
      first_d     = first_q;
      blast_d     = blast_q;
      mlast_d     = mlast_q;
      load        = 1'b0;
      ld_word     = '0;
      ld_mlast    = 1'b0;
      if (abort) begin
         state_d     = S_DATA;
         len_d       = '0;
         widx_d      = '0;
         pad80_d     = 1'b0;
         out_valid_d = 1'b0;
      end else begin
         if (free) begin
            out_valid_d = 1'b0;
         end
         unique case (state_q)
            S_DATA: begin
               if (accept) begin
                  if (in_keep) begin
                     len_d = len_q + LEN_W'(8);
                  end
                  if (pk_word_valid) begin
                     load    = 1'b1;
                     ld_word = pk_word;
                     if (in_last) begin
                        if (pk_pad_pend) begin
                           state_d = S_PAD_ZERO;
                           pad80_d = 1'b1;
                        end else begin
                           state_d = (widx_q == LAST_PAD_IDX) ? S_LEN_LO : S_PAD_ZERO;
                        end
                     end
                  end
               end
            end
            S_PAD_ZERO: begin
               if (free) begin
                  load    = 1'b1;
                  ld_word = pad80_q ? 32'(PAD_BYTE) : 32'd0;
                  pad80_d = 1'b0;
                  if (widx_q == LAST_PAD_IDX) begin
                     state_d = S_LEN_LO;
                  end
               end
            end
            S_LEN_LO: begin
               if (free) begin
                  load    = 1'b1;
                  ld_word = len_ext[31:0];
                  state_d = S_LEN_HI;
               end
            end
            S_LEN_HI: begin
               if (free) begin
                  load     = 1'b1;
                  ld_word  = len_ext[63:32];
                  ld_mlast = 1'b1;
                  len_d    = '0;
                  state_d  = S_DATA;
               end
            end
            default: state_d = S_DATA;
         endcase
         if (load) begin
            out_valid_d = 1'b1;
            out_word_d  = ld_word;
            out_idx_d   = widx_q;
            first_d     = (widx_q == 4'd0);
            blast_d     = (widx_q == 4'(WORDS_PER_BLOCK - 1));
            mlast_d     = ld_mlast;
            widx_d      = widx_q + 4'd1;
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_DATA;
         len_q       <= '0;
         widx_q      <= '0;
         pad80_q     <= 1'b0;
         rdy_en_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_word_q  <= '0;
         out_idx_q   <= '0;
         first_q     <= 1'b0;
         blast_q     <= 1'b0;
         mlast_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         widx_q      <= widx_d;
         pad80_q     <= pad80_d;
         rdy_en_q    <= 1'b1;
         out_valid_q <= out_valid_d;
         out_word_q  <= out_word_d;
         out_idx_q   <= out_idx_d;
         first_q     <= first_d;
         blast_q     <= blast_d;
         mlast_q     <= mlast_d;
      end
   end

   assign out_valid       = out_valid_q;
   assign out_word        = out_word_q;
   assign out_idx         = out_idx_q;
   assign out_block_first = first_q;
   assign out_block_last  = blast_q;
   assign out_msg_last    = mlast_q;

   // A keep-less beat is only meaningful as a message terminator
   assert property (@(posedge clk) disable iff (!rst_n)
                    (in_valid && in_ready && !in_keep) |-> in_last)
      else $error("md5_msg_padder: in_keep=0 beat without in_last");

   // Length words must land on their fixed block positions
   assert property (@(posedge clk) disable iff (!rst_n || abort)
                    (state_q == S_LEN_LO && free) |-> (widx_q == LEN_IDX_LO))
      else $error("md5_msg_padder: low length word misplaced");
   assert property (@(posedge clk) disable iff (!rst_n || abort)
                    (state_q == S_LEN_HI && free) |-> (widx_q == LEN_IDX_HI))
      else $error("md5_msg_padder: high length word misplaced");

endmodule

// File: tb/tb_md5_msg_padder.sv
// Randomized self-checking bench for md5_msg_padder against an RFC 1321 padding model.
module tb_md5_msg_padder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        abort = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = '0;
   logic        in_keep = 1'b0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_word;
   logic [3:0]  out_idx;
   logic        out_block_first;
   logic        out_block_last;
   logic        out_msg_last;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   byte unsigned msg_q[$];
   logic [31:0]  exp_q[$];

   always #5 clk = ~clk;

   md5_msg_padder #(.LEN_W(64)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .abort           (abort),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_data         (in_data),
      .in_keep         (in_keep),
      .in_last         (in_last),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_word        (out_word),
      .out_idx         (out_idx),
      .out_block_first (out_block_first),
      .out_block_last  (out_block_last),
      .out_msg_last    (out_msg_last)
   );

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Padded message as a byte list, then grouped into little-endian words
   function automatic void build_expected();
      byte unsigned     p[$];
      longint unsigned  bits;
      p = msg_q;
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      bits = 64'(msg_q.size()) * 64'd8;
      for (int i = 0; i < 8; i++) p.push_back(8'(bits >> (8 * i)));
      exp_q.delete();
      for (int i = 0; i < p.size(); i += 4) exp_q.push_back({p[i+3], p[i+2], p[i+1], p[i]});
   endfunction

   // Send msg_q (optionally terminated by an empty keep=0 beat) and check every output word
   task automatic run_msg(input bit tail_empty, input int rdy_pct, input bit stall_first);
      int nb, bi, wi, cyc, stall_cnt, w;
      bit exp_v;
      if (msg_q.size() == 0) tail_empty = 1'b1;
      nb = msg_q.size() + (tail_empty ? 1 : 0);
      build_expected();
      bi = 0; wi = 0; cyc = 0; stall_cnt = 0; exp_v = 1'b0;
      while (wi < exp_q.size() && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (bi < nb) begin
            in_valid = stall_first ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (bi < msg_q.size()) begin
               in_data = msg_q[bi];
               in_keep = 1'b1;
               in_last = !tail_empty && (bi == msg_q.size() - 1);
            end else begin
               in_data = 8'($urandom);
               in_keep = 1'b0;
               in_last = 1'b1;
            end
         end else begin
            in_valid = 1'b0;
            in_keep  = 1'b0;
            in_last  = 1'b0;
         end
         if (stall_first && wi == 0) out_ready = (stall_cnt >= 3);
         else out_ready = ($urandom_range(0, 99) < rdy_pct);
         #1;
         if (exp_v) check_eq("load_latency", 64'(out_valid), 64'd1);
         exp_v = 1'b0;
         if (out_valid) begin
            w = wi % 16;
            check_eq($sformatf("word%0d", wi), 64'(out_word), 64'(exp_q[wi]));
            check_eq($sformatf("idx%0d", wi), 64'(out_idx), 64'(w));
            check_eq($sformatf("first%0d", wi), 64'(out_block_first), 64'(w == 0));
            check_eq($sformatf("blast%0d", wi), 64'(out_block_last), 64'(w == 15));
            check_eq($sformatf("mlast%0d", wi), 64'(out_msg_last),
                     64'(wi == exp_q.size() - 1));
            if (!out_ready) begin
               check_eq("stall_in_ready", 64'(in_ready), 64'd0);
               stall_cnt++;
            end
         end
         if (bi == nb && wi < exp_q.size() - 1) check_eq("pad_in_ready", 64'(in_ready), 64'd0);
         if (out_valid && out_ready) wi++;
         if (in_valid && in_ready) begin
            exp_v = in_last || (bi % 4 == 3);
            bi++;
         end
      end
      if (wi < exp_q.size()) check_eq("msg_timeout", 64'(wi), 64'(exp_q.size()));
      @(negedge clk);
      in_valid  = 1'b0;
      in_keep   = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;
   endtask

   // Feed 10 bytes of a message, then kill it by abort or by reset
   task automatic partial_then_kill(input bit use_reset);
      int sent = 0;
      int guard = 0;
      out_ready = 1'b1;
      while (sent < 10 && guard < 200) begin
         @(negedge clk);
         guard++;
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         in_keep  = 1'b1;
         in_last  = 1'b0;
         #1;
         if (in_ready) sent++;
      end
      if (sent < 10) check_eq("partial_feed", 64'(sent), 64'd10);
      @(negedge clk);
      in_valid = 1'b0;
      if (use_reset) begin
         rst_n = 1'b0;
         #1;
         check_eq("midrst_valid", 64'(out_valid), 64'd0);
         check_eq("midrst_ready", 64'(in_ready), 64'd0);
         @(negedge clk);
         rst_n = 1'b1;
      end else begin
         abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
         #1;
         check_eq("abort_valid", 64'(out_valid), 64'd0);
      end
      out_ready = 1'b0;
   endtask

   task automatic set_abc();
      msg_q.delete();
      msg_q.push_back(8'h61);
      msg_q.push_back(8'h62);
      msg_q.push_back(8'h63);
   endtask

   initial begin
      int len;
      // Reset values
      repeat (3) @(negedge clk);
      #1;
      check_eq("rst_valid", 64'(out_valid), 64'd0);
      check_eq("rst_ready", 64'(in_ready), 64'd0);
      check_eq("rst_word", 64'(out_word), 64'd0);
      check_eq("rst_idx", 64'(out_idx), 64'd0);
      check_eq("rst_flags", 64'({out_block_first, out_block_last, out_msg_last}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("ready_held_low", 64'(in_ready), 64'd0);
      @(negedge clk);
      #1;
      check_eq("ready_rises", 64'(in_ready), 64'd1);

      // Empty message
      msg_q.delete();
      run_msg(1'b1, 100, 1'b0);
      // "abc"
      set_abc();
      run_msg(1'b0, 100, 1'b0);
      // 55 and 56 zero bytes: one block vs. spill into a second block
      msg_q.delete();
      repeat (55) msg_q.push_back(8'h00);
      run_msg(1'b0, 70, 1'b0);
      msg_q.push_back(8'h00);
      run_msg(1'b0, 70, 1'b0);
      // Four bytes with the first word stalled for three cycles
      msg_q.delete();
      repeat (4) msg_q.push_back(8'($urandom));
      run_msg(1'b0, 100, 1'b1);
      // Abort mid-message, then a clean "abc"
      partial_then_kill(1'b0);
      set_abc();
      run_msg(1'b0, 100, 1'b0);
      // Reset mid-message, then a clean "abc"
      partial_then_kill(1'b1);
      set_abc();
      run_msg(1'b0, 100, 1'b0);
      // Random messages around block boundaries and beyond
      for (int m = 0; m < 30; m++) begin
         msg_q.delete();
         len = (m < 8) ? (52 + m) : $urandom_range(0, 140);
         for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
         run_msg(1'($urandom_range(0, 1)), $urandom_range(30, 100), 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
